midi_rx: RTL and testbench
==========================

Name: midi_rx

Overview:
- Receives a serial MIDI stream (31250 baud, 8N1, line idles high, LSB first) and decodes channel voice messages.
- Front end: UART receiver with mid-bit sampling. Back end: message parser with running status.
- Sits between the MIDI IN opto-isolator pin and downstream control logic. It is the receiving counterpart of the existing MIDI transmitter.
- One-cycle pulses report each received byte and each completed message.

Parameters:
- CLKS_PER_BIT, default 3200: clk cycles per bit (100 MHz / 31250). Must be even and >= 8.
- LED_HOLD, default 2_000_000: cycles the activity LED stays lit after the last good byte (20 ms at 100 MHz).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- midi_in  in  1  raw serial line; asynchronous to clk
- byte_valid  out  1  one-cycle pulse: byte_data holds a correctly framed byte
- byte_data  out  8  last received byte
- frame_err  out  1  one-cycle pulse: stop bit sampled low
- msg_valid  out  1  one-cycle pulse: msg_* hold a complete message
- msg_status  out  8  status byte of the message (running status applied)
- msg_data1  out  8  first data byte
- msg_data2  out  8  second data byte; 0 for one-data-byte messages
- led  out  1  activity indicator

Behaviour:
- Reset (rst low, async):
  - All outputs 0.
  - Synchronizer flops set to 1 (idle).
  - UART FSM to IDLE.
  - Running status cleared; parser data count cleared.
- Input sync: 2-flop synchronizer on midi_in. All logic uses the synced value s_in.
- UART FSM states: IDLE, START, DATA, STOP, WAIT_HIGH. A single counter bit_cnt is reloaded on every state entry.
  - IDLE: when s_in == 0, go to START with bit_cnt = CLKS_PER_BIT/2 - 1.
  - START: count down. At 0, sample s_in.
    - Sample 1: false start, return to IDLE, no pulses.
    - Sample 0: go to DATA with bit_cnt = CLKS_PER_BIT - 1 and bit index 0.
  - DATA: at each counter expiry, shift s_in into bit [index] (LSB first) and reload the counter. After index 7 is sampled, go to STOP.
  - STOP: at counter expiry, sample s_in.
    - Sample 1: byte_data <= shift reg, byte_valid = 1 for one cycle, go to IDLE.
    - Sample 0: frame_err = 1 for one cycle, byte discarded, byte_data unchanged, go to WAIT_HIGH.
  - WAIT_HIGH: stay until s_in == 1, then go to IDLE. This covers a break or line held low.
  - Latency: byte_valid asserts 2 (sync) + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT cycles after the falling edge of the start bit, ±1 cycle.
- Parser (acts in the cycle byte_valid is high; msg_valid fires the following cycle):
  - 0x80-0xEF (channel status):
    - run_status <= byte; data count <= 0.
    - Bytes needed: 2 for high nibble 8, 9, A, B, E; 1 for high nibble C, D.
  - 0xF0-0xF7 (system common/SysEx): run_status cleared. Following data bytes are dropped until a new channel status arrives.
  - 0xF8-0xFF (real-time): ignored entirely. Running status and data count are unchanged, so a message split by a real-time byte still completes.
  - 0x00-0x7F (data):
    - If run_status == 0, drop the byte.
    - First data byte: store as d1.
    - When the byte count is met: msg_valid = 1; msg_status = run_status; msg_data1 = d1 (or this byte for one-byte types); msg_data2 = this byte or 0; count <= 0. run_status is kept, so later data bytes reuse it.
  - msg_* hold their values until the next msg_valid.
  - frame_err does not alter parser state.
- LED: reload a hold counter to LED_HOLD on each byte_valid. led = 1 while the counter != 0, decrement each cycle.
- Reset mid-byte aborts the byte: no pulses, and the next byte is received normally.

Test Plan:
- (CLKS_PER_BIT = 16, LED_HOLD = 100) Send 0xC0, 0x2E, 0x7F.
  - 3 byte_valid pulses: 0xC0, 0x2E, 0x7F.
  - msg_valid once after 0x2E with status 0xC0, d1 0x2E, d2 0x00.
  - 0x7F produces a second msg_valid (running status) with d1 0x7F, d2 0x00.
- Send 0x90, 0x3C, 0x64, then 0x40, 0x00.
  - Two msg_valid pulses: (0x90, 0x3C, 0x64) and (0x90, 0x40, 0x00).
- Send 0xB1, 0x07, 0xF8, 0x50.
  - One msg_valid (0xB1, 0x07, 0x50); the 0xF8 byte_valid is seen but does not disturb the message.
- Send 0x42 after reset, then 0xF0, 0x01.
  - Both data bytes get byte_valid only, no msg_valid.
- Send 0x90 with the stop bit driven low, then hold the line low for 40 cycles, then release and send 0x80.
  - frame_err pulses once, with no byte_valid.
  - byte_valid 0x80 follows after release.
- Drive a 4-cycle low glitch: no pulses, FSM back to IDLE.
- Assert rst mid-DATA: outputs 0; the next full byte 0xA5 is received correctly.
- Check led is high for exactly 100 cycles after the last byte_valid.

Source files
------------

// File: rtl/midi_rx.sv
// midi_rx: serial MIDI receiver with a channel voice message parser.
//
// The front end is a UART receiver: a 2-flop synchronizer, then an FSM
// that samples in the middle of each bit (31250 baud, 8N1, idle high,
// LSB first). The back end tracks running status and assembles channel
// voice messages from the byte stream.
//
// Ports:
//   clk         system clock
//   rst         asynchronous, active-low reset
//   midi_in     raw serial line, asynchronous to clk
//   byte_valid  one-cycle pulse: byte_data holds a correctly framed byte
//   byte_data   last correctly framed byte
//   frame_err   one-cycle pulse: stop bit sampled low, byte discarded
//   msg_valid   one-cycle pulse: msg_* hold a complete message
//   msg_status  status byte of the message (running status applied)
//   msg_data1   first data byte
//   msg_data2   second data byte, 0 for one-data-byte messages
//   led         activity indicator, lit LED_HOLD cycles after a good byte
module midi_rx #(
  parameter int CLKS_PER_BIT = 3200,
  parameter int LED_HOLD     = 2_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       midi_in,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       frame_err,
  output logic       msg_valid,
  output logic [7:0] msg_status,
  output logic [7:0] msg_data1,
  output logic [7:0] msg_data2,
  output logic       led
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int LW = $clog2(LED_HOLD + 1);
  localparam logic [CW-1:0] HALF_LOAD = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_LOAD = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_ZERO  = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [LW-1:0] LED_LOAD  = LW'(LED_HOLD);
  localparam logic [LW-1:0] LED_ZERO  = {LW{1'b0}};
  localparam logic [LW-1:0] LED_ONE   = LW'(1);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_STOP      = 3'd3,
    ST_WAIT_HIGH = 3'd4
  } uart_state_t;

  // Channel status types C (program change) and D (channel pressure)
  // carry a single data byte; all other channel types carry two.
  function automatic logic needs_two(input logic [7:0] status);
    return !((status[7:4] == 4'hC) || (status[7:4] == 4'hD));
  endfunction

  logic          sync_r;
  logic          s_in_r;
  uart_state_t   state_r;
  logic [CW-1:0] bit_cnt_r;
  logic [2:0]    bit_idx_r;
  logic [7:0]    shift_r;
  logic [7:0]    run_status_r;
  logic          have_d1_r;
  logic [7:0]    d1_r;
  logic [LW-1:0] led_cnt_r;

  // Two-flop synchronizer; resets to the idle (high) line level.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_r <= 1'b1;
      s_in_r <= 1'b1;
    end else begin
      sync_r <= midi_in;
      s_in_r <= sync_r;
    end
  end

  // UART receive FSM: one shared counter reloaded on each state entry.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r    <= ST_IDLE;
      bit_cnt_r  <= CNT_ZERO;
      bit_idx_r  <= 3'd0;
      shift_r    <= 8'h00;
      byte_valid <= 1'b0;
      byte_data  <= 8'h00;
      frame_err  <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (!s_in_r) begin
            state_r   <= ST_START;
            bit_cnt_r <= HALF_LOAD;
          end
        end
        ST_START: begin
          if (bit_cnt_r != CNT_ZERO) begin
            bit_cnt_r <= bit_cnt_r - CNT_ONE;
          end else if (s_in_r) begin
            // Line went back high before mid-bit: treat as a glitch.
            state_r   <= ST_IDLE;
            bit_cnt_r <= CNT_ZERO;
          end else begin
            state_r   <= ST_DATA;
            bit_cnt_r <= FULL_LOAD;
            bit_idx_r <= 3'd0;
          end
        end
        ST_DATA: begin
          if (bit_cnt_r != CNT_ZERO) begin
            bit_cnt_r <= bit_cnt_r - CNT_ONE;
          end else begin
            shift_r[bit_idx_r] <= s_in_r;
            bit_cnt_r          <= FULL_LOAD;
            if (bit_idx_r == 3'd7) begin
              state_r <= ST_STOP;
            end else begin
              bit_idx_r <= bit_idx_r + 3'd1;
            end
          end
        end
        ST_STOP: begin
          if (bit_cnt_r != CNT_ZERO) begin
            bit_cnt_r <= bit_cnt_r - CNT_ONE;
          end else begin
            bit_cnt_r <= CNT_ZERO;
            if (s_in_r) begin
              byte_data  <= shift_r;
              byte_valid <= 1'b1;
              state_r    <= ST_IDLE;
            end else begin
              // Bad stop bit: drop the byte and wait out a break.
              frame_err <= 1'b1;
              state_r   <= ST_WAIT_HIGH;
            end
          end
        end
        ST_WAIT_HIGH: begin
          if (s_in_r) begin
            state_r <= ST_IDLE;
          end
        end
        default: begin
          state_r   <= ST_IDLE;
          bit_cnt_r <= CNT_ZERO;
        end
      endcase
    end
  end

  // Message parser with running status; acts on each byte_valid pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      run_status_r <= 8'h00;
      have_d1_r    <= 1'b0;
      d1_r         <= 8'h00;
      msg_valid    <= 1'b0;
      msg_status   <= 8'h00;
      msg_data1    <= 8'h00;
      msg_data2    <= 8'h00;
    end else begin
      msg_valid <= 1'b0;
      if (byte_valid) begin
        if (byte_data[7:4] == 4'hF) begin
          // 0xF8-0xFF real-time bytes leave the parser untouched;
          // 0xF0-0xF7 cancel running status.
          if (!byte_data[3]) begin
            run_status_r <= 8'h00;
            have_d1_r    <= 1'b0;
          end
        end else if (byte_data[7]) begin
          run_status_r <= byte_data;
          have_d1_r    <= 1'b0;
        end else if (run_status_r != 8'h00) begin
          if (!needs_two(run_status_r)) begin
            msg_valid  <= 1'b1;
            msg_status <= run_status_r;
            msg_data1  <= byte_data;
            msg_data2  <= 8'h00;
          end else if (!have_d1_r) begin
            d1_r      <= byte_data;
            have_d1_r <= 1'b1;
          end else begin
            msg_valid  <= 1'b1;
            msg_status <= run_status_r;
            msg_data1  <= d1_r;
            msg_data2  <= byte_data;
            have_d1_r  <= 1'b0;
          end
        end
      end
    end
  end

  // Activity LED: retriggerable hold counter, led mirrors counter != 0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      led_cnt_r <= LED_ZERO;
      led       <= 1'b0;
    end else if (byte_valid) begin
      led_cnt_r <= LED_LOAD;
      led       <= (LED_LOAD != LED_ZERO);
    end else if (led_cnt_r != LED_ZERO) begin
      led_cnt_r <= led_cnt_r - LED_ONE;
      led       <= (led_cnt_r != LED_ONE);
    end else begin
      led <= 1'b0;
    end
  end

endmodule

// File: tb/tb_midi_rx.sv
// tb_midi_rx: randomized and directed stimulus for midi_rx, checked every
// cycle against a byte-level scoreboard and a message-level parser model.
module tb_midi_rx;

  localparam int CPB  = 16;
  localparam int LEDH = 100;
  localparam int LAT  = 2 + CPB / 2 + 9 * CPB;

  logic       clk;
  logic       rst;
  logic       midi_in;
  logic       byte_valid;
  logic [7:0] byte_data;
  logic       frame_err;
  logic       msg_valid;
  logic [7:0] msg_status;
  logic [7:0] msg_data1;
  logic [7:0] msg_data2;
  logic       led;

  midi_rx #(.CLKS_PER_BIT(CPB), .LED_HOLD(LEDH)) dut (
    .clk(clk), .rst(rst), .midi_in(midi_in),
    .byte_valid(byte_valid), .byte_data(byte_data), .frame_err(frame_err),
    .msg_valid(msg_valid), .msg_status(msg_status),
    .msg_data1(msg_data1), .msg_data2(msg_data2), .led(led)
  );

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  logic [7:0]  exp_q[$];
  int          fall_q[$];
  int          ferr_pend = 0;
  logic [23:0] pin_q[$];
  int          led_done = -1;

  // Parser model state.
  logic [7:0] m_run;
  logic [7:0] m_d1;
  int         m_have;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name, input string what);
    tests++;
    fails++;
    $display("FAIL %s: %s (cycle %0d)", name, what, cyc);
  endtask

  task automatic model_reset();
    m_run  = 8'h00;
    m_d1   = 8'h00;
    m_have = 0;
  endtask

  // Message rules: status bytes set running status, F0-F7 clear it,
  // F8-FF are transparent, data bytes complete messages of 1 or 2 bytes.
  task automatic model_byte(input logic [7:0] b, output bit emit, output logic [23:0] msg);
    int need;
    emit = 1'b0;
    msg  = 24'h000000;
    if (b >= 8'hF0 && b <= 8'hF7) begin
      m_run  = 8'h00;
      m_have = 0;
    end else if (b >= 8'h80 && b <= 8'hEF) begin
      m_run  = b;
      m_have = 0;
    end else if (b <= 8'h7F && m_run != 8'h00) begin
      need = (m_run[7:4] == 4'hC || m_run[7:4] == 4'hD) ? 1 : 2;
      if (m_have + 1 == need) begin
        emit   = 1'b1;
        msg    = (need == 1) ? {m_run, b, 8'h00} : {m_run, m_d1, b};
        m_have = 0;
      end else begin
        m_d1   = b;
        m_have = m_have + 1;
      end
    end
  endtask

  task automatic pin_feed(input logic [7:0] b);
    bit e;
    logic [23:0] m;
    model_byte(b, e, m);
    if (e) pin_q.push_back(m);
  endtask

  // Drive the line to v for n (>= 1) clock cycles, ending at posedge+1.
  task automatic hold_line(input logic v, input int n);
    midi_in = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit good, input int hold, input int gap);
    @(posedge clk);
    #1;
    midi_in = 1'b0;
    if (good) begin
      exp_q.push_back(b);
      fall_q.push_back(cyc);
    end else begin
      ferr_pend++;
    end
    hold_line(1'b0, CPB);
    for (int i = 0; i < 8; i++) hold_line(b[i], CPB);
    if (good) hold_line(1'b1, CPB);
    else      hold_line(1'b0, CPB + hold);
    hold_line(1'b1, gap);
  endtask

  task automatic glitch(input int len);
    @(posedge clk);
    #1;
    hold_line(1'b0, len);
    hold_line(1'b1, 3 * CPB);
  endtask

  // Per-cycle compare process.
  initial begin
    bit          pend;
    logic [23:0] pend_msg;
    logic [23:0] held;
    int          hold_m;
    bit          led_prev;
    int          led_run;
    bit          e;
    logic [23:0] m;
    logic [7:0]  eb;
    logic [7:0]  last_byte;
    int          fc;
    int          lat;
    pend = 1'b0; pend_msg = 24'h0; held = 24'h0; hold_m = 0;
    led_prev = 1'b0; led_run = 0; last_byte = 8'h00;
    forever begin
      @(negedge clk);
      if (!rst) begin
        check("rst_pulses", {28'h0, byte_valid, frame_err, msg_valid, led}, 32'h0);
        check("rst_data", {byte_data, msg_status, msg_data1, msg_data2}, 32'h0);
        model_reset();
        pend = 1'b0; held = 24'h0; hold_m = 0; last_byte = 8'h00;
        led_prev = 1'b0; led_run = 0;
      end else begin
        check("msg_valid", {31'h0, msg_valid}, {31'h0, pend});
        if (pend) held = pend_msg;
        pend = 1'b0;
        check("msg_fields", {8'h00, msg_status, msg_data1, msg_data2}, {8'h00, held});
        if (byte_valid) begin
          if (exp_q.size() == 0) begin
            fail_now("unexpected_byte", $sformatf("got byte_valid with %0h, required none", byte_data));
          end else begin
            eb = exp_q.pop_front();
            fc = fall_q.pop_front();
            check("byte_data", {24'h0, byte_data}, {24'h0, eb});
            lat = cyc - fc;
            tests++;
            // One extra cycle of slack for where the bench places the edge.
            if (lat < LAT - 2 || lat > LAT + 2) begin
              fails++;
              $display("FAIL latency: got %0d cycles, required %0d +-2", lat, LAT);
            end
            model_byte(eb, e, m);
            pend = e;
            pend_msg = m;
            last_byte = eb;
          end
        end
        if (frame_err) begin
          if (ferr_pend == 0) fail_now("unexpected_frame_err", "got frame_err, required none");
          else ferr_pend--;
          check("frame_byte_data", {24'h0, byte_data}, {24'h0, last_byte});
          check("frame_no_byte", {31'h0, byte_valid}, 32'h0);
        end
        check("led", {31'h0, led}, {31'h0, (hold_m != 0)});
        if (byte_valid) hold_m = LEDH;
        else if (hold_m > 0) hold_m--;
        if (led) led_run++;
        else if (led_prev) begin
          led_done = led_run;
          led_run = 0;
        end
        if (byte_valid) led_run = 0;
        led_prev = led;
      end
    end
  end

  initial begin
    rst = 1'b0;
    midi_in = 1'b1;

    // Pin the parser model with hand-derived message lists.
    model_reset(); pin_q.delete();
    pin_feed(8'hC0); pin_feed(8'h2E); pin_feed(8'h7F);
    check("pin_c0_count", pin_q.size(), 32'd2);
    check("pin_c0_m0", {8'h0, pin_q[0]}, 32'h00C02E00);
    check("pin_c0_m1", {8'h0, pin_q[1]}, 32'h00C07F00);
    model_reset(); pin_q.delete();
    pin_feed(8'h90); pin_feed(8'h3C); pin_feed(8'h64); pin_feed(8'h40); pin_feed(8'h00);
    check("pin_90_count", pin_q.size(), 32'd2);
    check("pin_90_m0", {8'h0, pin_q[0]}, 32'h00903C64);
    check("pin_90_m1", {8'h0, pin_q[1]}, 32'h00904000);
    model_reset(); pin_q.delete();
    pin_feed(8'hB1); pin_feed(8'h07); pin_feed(8'hF8); pin_feed(8'h50);
    check("pin_b1_count", pin_q.size(), 32'd1);
    check("pin_b1_m0", {8'h0, pin_q[0]}, 32'h00B10750);
    model_reset(); pin_q.delete();
    pin_feed(8'h42); pin_feed(8'hF0); pin_feed(8'h01); pin_feed(8'hD5); pin_feed(8'h11);
    check("pin_sysex_count", pin_q.size(), 32'd1);
    check("pin_sysex_m0", {8'h0, pin_q[0]}, 32'h00D51100);

    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    hold_line(1'b1, 10);

    // Directed sequences.
    send_byte(8'h42, 1'b1, 0, 4);
    send_byte(8'hF0, 1'b1, 0, 4);
    send_byte(8'h01, 1'b1, 0, 4);
    send_byte(8'hC0, 1'b1, 0, 2);
    send_byte(8'h2E, 1'b1, 0, 2);
    send_byte(8'h7F, 1'b1, 0, 2);
    send_byte(8'h90, 1'b1, 0, 3);
    send_byte(8'h3C, 1'b1, 0, 3);
    send_byte(8'h64, 1'b1, 0, 3);
    send_byte(8'h40, 1'b1, 0, 3);
    send_byte(8'h00, 1'b1, 0, 3);
    send_byte(8'hB1, 1'b1, 0, 5);
    send_byte(8'h07, 1'b1, 0, 5);
    send_byte(8'hF8, 1'b1, 0, 5);
    send_byte(8'h50, 1'b1, 0, 5);
    send_byte(8'h90, 1'b0, 40, 20);
    send_byte(8'h80, 1'b1, 0, 10);
    glitch(4);

    // Reset in the middle of a byte, then a clean byte.
    @(posedge clk);
    #1;
    hold_line(1'b0, CPB);
    hold_line(1'b1, CPB);
    hold_line(1'b0, CPB);
    rst = 1'b0;
    hold_line(1'b1, 3);
    rst = 1'b1;
    hold_line(1'b1, 10);
    led_done = -1;
    send_byte(8'hA5, 1'b1, 0, 150);
    check("led_hold_cycles", led_done, 32'd100);

    // Randomized traffic.
    for (int i = 0; i < 40; i++) begin
      int r;
      bit bad;
      logic [7:0] b;
      r = $urandom_range(0, 99);
      if (r < 30)      b = 8'h80 + 8'($urandom_range(0, 111));
      else if (r < 40) b = 8'hF0 + 8'($urandom_range(0, 15));
      else             b = 8'($urandom_range(0, 127));
      bad = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 19) == 0) glitch($urandom_range(1, 5));
      send_byte(b, !bad, $urandom_range(0, 60), bad ? $urandom_range(4, 30) : $urandom_range(2, 30));
    end

    led_done = -1;
    send_byte(8'h3A, 1'b1, 0, 150);
    check("led_hold_final", led_done, 32'd100);
    repeat (50) @(posedge clk);
    check("bytes_outstanding", exp_q.size(), 32'd0);
    check("frame_err_outstanding", ferr_pend, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
